// File: rtl/note_feed_if.sv
// note_feed_if: control, song-ROM and note-output bundle of note_feed_scheduler
// Ports (master = scheduler side):
//   in  start, pause, stop       playback control from the mode FSM
//   out rom_addr / in rom_data   song ROM read port, data valid one cycle after address
//   out note, shift, output_ready, busy, done, song_pos   play-mode display/audio feed
interface note_feed_if #(
    parameter int ADDR_W = 8
) ();
    logic              start;
    logic              pause;
    logic              stop;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [7:0]        note;
    logic [1:0]        shift;
    logic              output_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] song_pos;
    modport master (
        input  start, pause, stop, rom_data,
        output rom_addr, note, shift, output_ready, busy, done, song_pos
    );
    modport slave (
        output start, pause, stop, rom_data,
        input  rom_addr, note, shift, output_ready, busy, done, song_pos
    );
endinterface

// File: rtl/note_feed_scheduler.sv
// note_feed_scheduler: plays song-ROM entries as timed notes separated by silent gaps
// Ports:
//   vga_clk  sole clock, rising edge
//   rst      synchronous active-high reset
//   bus      note_feed_if.master: start/pause/stop control, rom_addr/rom_data ROM port,
//            note/shift/output_ready/busy/done/song_pos outputs
// Config: define NOTE_FEED_LOOP_EN to loop back to address 0 at the end marker or the
//         address wrap instead of returning to IDLE.
module note_feed_scheduler #(
    parameter int TICK_PERIOD = 100000,
    parameter int GAP_TICKS   = 1,
    parameter int ADDR_W      = 8
) (
    input logic         vga_clk,
    input logic         rst,
    note_feed_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d, song_pos_q, song_pos_d;
    logic [7:0]        note_q, note_d;
    logic [1:0]        shift_q, shift_d;
    logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic [19:0]       div_q, div_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              run, tick, adv;

    // the divider only runs while timing a note or gap, and pause freezes it
    assign run  = (state_q == PLAY || state_q == GAP) && !bus.pause;
    assign tick = run && div_q == 20'(TICK_PERIOD - 1);

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        song_pos_d = song_pos_q;
        note_d     = note_q;
        shift_d    = shift_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        adv        = 1'b0;
        div_d      = run ? (tick ? '0 : div_q + 20'd1) : div_q;
        cnt_d      = tick ? cnt_q - 6'd1 : cnt_q;
        case (state_q)
            FETCH: state_d = LOAD;
            LOAD: begin
                if (bus.rom_data[5:0] == 6'd0) begin
                    done_d = 1'b1;
`ifdef NOTE_FEED_LOOP_EN
                    rom_addr_d = '0;
                    state_d    = FETCH;
`else
                    state_d    = IDLE;
`endif
                end else begin
                    note_d     = bus.rom_data[15:8];
                    shift_d    = bus.rom_data[7:6];
                    song_pos_d = rom_addr_q;
                    cnt_d      = bus.rom_data[5:0];
                    div_d      = '0;
                    ready_d    = 1'b1;
                    state_d    = PLAY;
                end
            end
            PLAY: begin
                if (tick && cnt_q == 6'd1) begin
                    ready_d = 1'b0;
                    note_d  = '0;
                    if (GAP_TICKS > 0) begin
                        cnt_d   = 6'(GAP_TICKS);
                        state_d = GAP;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            GAP: adv = tick && cnt_q == 6'd1;
            default: ;
        endcase
        // moving past the last address is the end of a pass through the song
        if (adv) begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = FETCH;
            if (&rom_addr_q) begin
                done_d = 1'b1;
`ifndef NOTE_FEED_LOOP_EN
                state_d = IDLE;
`endif
            end
        end
        if (bus.start) begin
            state_d    = FETCH;
            rom_addr_d = '0;
            song_pos_d = '0;
            note_d     = '0;
            shift_d    = '0;
            ready_d    = 1'b0;
            done_d     = 1'b0;
            div_d      = '0;
            cnt_d      = '0;
        end
        if (bus.stop) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
        // IDLE always presents reset values; done survives only for a natural song end
        if (state_d == IDLE) begin
            rom_addr_d = '0;
            song_pos_d = '0;
            note_d     = '0;
            shift_d    = '0;
            ready_d    = 1'b0;
            div_d      = '0;
            cnt_d      = '0;
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            song_pos_q <= '0;
            note_q     <= '0;
            shift_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            song_pos_q <= song_pos_d;
            note_q     <= note_d;
            shift_q    <= shift_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.song_pos     = song_pos_q;
    assign bus.note         = note_q;
    assign bus.shift        = shift_q;
    assign bus.output_ready = ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule
